// File: rtl/jtframe_tilerom_arb.sv
// Round-robin arbiter sharing one ROM/SDRAM port among three tile requesters.
// Each requester keeps a one-entry cache of its last served address and data.
module jtframe_tilerom_arb #(
  parameter int AW = 20,
  parameter int DW = 32
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_cs,
  input  logic          req1_cs,
  input  logic          req2_cs,
  input  logic [AW-1:0] req0_addr,
  input  logic [AW-1:0] req1_addr,
  input  logic [AW-1:0] req2_addr,
  output logic          req0_ok,
  output logic          req1_ok,
  output logic          req2_ok,
  output logic [DW-1:0] req0_data,
  output logic [DW-1:0] req1_data,
  output logic [DW-1:0] req2_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ok,
  input  logic [DW-1:0] rom_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]    cs_v;
  logic [AW-1:0] addr_v [3];
  logic [AW-1:0] served [3];
  logic [DW-1:0] data   [3];
  logic [2:0]    valid;
  logic [2:0]    hit;
  logic [2:0]    pend;
  logic [1:0]    gnt;
  logic [1:0]    last;
  logic [1:0]    pick;
  logic          any_pend;
  logic          grant_en;
  logic          done;

  function automatic logic [1:0] rr_next(
    input logic [1:0] x
  );
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign cs_v      = {req2_cs, req1_cs, req0_cs};
  assign addr_v[0] = req0_addr;
  assign addr_v[1] = req1_addr;
  assign addr_v[2] = req2_addr;

  always_comb begin
    hit  = '0;
    pend = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i]  = valid[i] &&
                (addr_v[i] == served[i]);
      pend[i] = cs_v[i] && !hit[i];
    end
  end

  assign any_pend  = |pend;
  assign req0_ok   = cs_v[0] & hit[0];
  assign req1_ok   = cs_v[1] & hit[1];
  assign req2_ok   = cs_v[2] & hit[2];
  assign req0_data = data[0];
  assign req1_data = data[1];
  assign req2_data = data[2];

  // Search starts just after the last completed grant.
  always_comb begin : rr_pick
    logic [1:0] cand;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    cand  = rr_next(last);
    for (int i = 0; i < 3; i++) begin
      if (!found && pend[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
      cand = rr_next(cand);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (any_pend) state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_WAIT;
      ST_WAIT:   if (rom_ok) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // SETTLE drops any rom_ok left over from the previous access.
  always_comb begin
    grant_en = (state == ST_IDLE) && any_pend;
    done     = (state == ST_WAIT) && rom_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      gnt      <= 2'd0;
      last     <= 2'd2;
      valid    <= '0;
      for (int i = 0; i < 3; i++) begin
        served[i] <= '0;
        data[i]   <= '0;
      end
    end else begin
      if (grant_en) begin
        rom_cs   <= 1'b1;
        rom_addr <= addr_v[pick];
        gnt      <= pick;
      end
      if (done) begin
        rom_cs <= 1'b0;
        last   <= gnt;
      end
      for (int i = 0; i < 3; i++) begin
        if (done && gnt == 2'(i)) begin
          data[i]   <= rom_data;
          served[i] <= rom_addr;
          valid[i]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_tilerom_arb.sv
// Self-checking bench for jtframe_tilerom_arb.
// Directed scenarios plus a randomized run against a transaction model.
module tb_jtframe_tilerom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs [3];
  logic [19:0] ad [3];
  logic        ok [3];
  logic [31:0] dt [3];
  logic        rom_cs;
  logic [19:0] rom_addr;
  logic        rom_ok;
  logic [31:0] rom_data;
  logic        use_manual;
  logic [31:0] manual;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] romfn(input logic [19:0] a);
    return ({12'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign rom_data = use_manual ? manual : romfn(rom_addr);

  jtframe_tilerom_arb #(.AW(20), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req0_cs(cs[0]), .req1_cs(cs[1]), .req2_cs(cs[2]),
    .req0_addr(ad[0]), .req1_addr(ad[1]), .req2_addr(ad[2]),
    .req0_ok(ok[0]), .req1_ok(ok[1]), .req2_ok(ok[2]),
    .req0_data(dt[0]), .req1_data(dt[1]), .req2_data(dt[2]),
    .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_ok(rom_ok), .rom_data(rom_data)
  );

  // Transaction-level reference: one transfer in flight at a time,
  // ROM answer accepted only from the second cycle after the grant.
  logic        m_busy;
  int          m_age;
  int          m_gnt;
  int          m_last;
  int          m_n;
  logic [19:0] m_addr;
  logic        m_valid [3];
  logic [19:0] m_served [3];
  logic [31:0] m_data [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_gnt = 0; m_last = 2; m_addr = '0;
      for (int i = 0; i < 3; i++) begin
        m_valid[i] = 0; m_served[i] = '0; m_data[i] = '0;
      end
    end else if (!m_busy) begin
      for (int k = 1; k <= 3; k++) begin
        m_n = (m_last + k) % 3;
        if (!m_busy && cs[m_n] && !(m_valid[m_n] && ad[m_n] == m_served[m_n])) begin
          m_busy = 1; m_gnt = m_n; m_addr = ad[m_n]; m_age = 0;
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (rom_ok) begin
      m_data[m_gnt] = rom_data;
      m_served[m_gnt] = m_addr;
      m_valid[m_gnt] = 1;
      m_last = m_gnt;
      m_busy = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin cs[i] = 0; ad[i] = '0; end
    rom_ok = 0; use_manual = 0; manual = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin cs[i] = 1; ad[i] = 20'(i); end
    rom_ok = 1; use_manual = 0; manual = '0;
    tick(); tick();
    n_cmp++; if (rom_cs !== 1'b0) begin n_bad++; $display("FAIL reset_rom_cs: got %b expected 0", rom_cs); end
    n_cmp++; if (rom_addr !== 20'h0) begin n_bad++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ok[i] !== 1'b0 || dt[i] !== 32'h0) begin
        n_bad++; $display("FAIL reset_req%0d: ok=%b data=%h expected ok=0 data=0", i, ok[i], dt[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    use_manual = 1; manual = 32'hDEADBEEF; rom_ok = 1;
    cs[0] = 1; ad[0] = 20'h00123;
    tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 20'h00123) begin
      n_bad++; $display("FAIL single_grant: rom_cs=%b rom_addr=%h expected 1/00123", rom_cs, rom_addr);
    end
    tick();
    n_cmp++; if (ok[0] !== 1'b0) begin n_bad++; $display("FAIL single_early_ok: got %b expected 0", ok[0]); end
    tick();
    n_cmp++; if (ok[0] !== 1'b1 || dt[0] !== 32'hDEADBEEF || rom_cs !== 1'b0) begin
      n_bad++; $display("FAIL single_done: ok=%b data=%h rom_cs=%b expected 1/deadbeef/0", ok[0], dt[0], rom_cs);
    end
  endtask

  task automatic test_round_robin();
    logic [19:0] order[$];
    int          when[$];
    logic        prev;
    do_reset();
    rom_ok = 1;
    ad[0] = 20'h10; ad[1] = 20'h20; ad[2] = 20'h30;
    for (int i = 0; i < 3; i++) cs[i] = 1;
    prev = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rom_cs && !prev) begin order.push_back(rom_addr); when.push_back(c); end
      prev = rom_cs;
    end
    n_cmp++; if (order.size() != 3 || order[0] !== 20'h10 || order[1] !== 20'h20 || order[2] !== 20'h30) begin
      n_bad++; $display("FAIL rr_order: got %p expected '{10,20,30}", order);
    end
    n_cmp++; if (when.size() != 3 || when[1] - when[0] != 3 || when[2] - when[1] != 3) begin
      n_bad++; $display("FAIL rr_back_to_back: grant cycles %p expected spacing 3", when);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ok[i] !== 1'b1 || dt[i] !== romfn(ad[i])) begin
        n_bad++; $display("FAIL rr_data%0d: ok=%b data=%h expected 1/%h", i, ok[i], dt[i], romfn(ad[i]));
      end
    end
    ad[0] = 20'h11; ad[2] = 20'h31;
    #1;
    n_cmp++; if (ok[0] !== 1'b0 || ok[1] !== 1'b1 || ok[2] !== 1'b0) begin
      n_bad++; $display("FAIL rr_miss: ok=%b%b%b expected 0,1,0", ok[0], ok[1], ok[2]);
    end
    order.delete();
    prev = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rom_cs && !prev) order.push_back(rom_addr);
      prev = rom_cs;
    end
    n_cmp++; if (order.size() != 2 || order[0] !== 20'h11 || order[1] !== 20'h31) begin
      n_bad++; $display("FAIL rr_order2: got %p expected '{11,31}", order);
    end
  endtask

  task automatic test_stale_ok();
    do_reset();
    use_manual = 1; manual = 32'h11111111; rom_ok = 0;
    cs[1] = 1; ad[1] = 20'h77;
    tick();
    rom_ok = 1; manual = 32'hBAD0BAD0;
    tick();
    rom_ok = 0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (ok[1] !== 1'b0 || rom_cs !== 1'b1) begin
        n_bad++; $display("FAIL stale_ok_c%0d: ok=%b rom_cs=%b expected 0/1", c, ok[1], rom_cs);
      end
      tick();
    end
    rom_ok = 1; manual = 32'h600DF00D;
    tick();
    n_cmp++; if (ok[1] !== 1'b1 || dt[1] !== 32'h600DF00D) begin
      n_bad++; $display("FAIL stale_ok_late: ok=%b data=%h expected 1/600df00d", ok[1], dt[1]);
    end
  endtask

  task automatic test_addr_change();
    do_reset();
    rom_ok = 0;
    cs[1] = 1; ad[1] = 20'h40;
    tick();
    tick();
    ad[1] = 20'h41; rom_ok = 1;
    tick();
    n_cmp++; if (rom_cs !== 1'b0 || ok[1] !== 1'b0) begin
      n_bad++; $display("FAIL chg_done: rom_cs=%b ok=%b expected 0/0", rom_cs, ok[1]);
    end
    ad[1] = 20'h40;
    #1;
    n_cmp++; if (ok[1] !== 1'b1 || dt[1] !== romfn(20'h40)) begin
      n_bad++; $display("FAIL chg_served40: ok=%b data=%h expected 1/%h", ok[1], dt[1], romfn(20'h40));
    end
    ad[1] = 20'h41;
    tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 20'h41) begin
      n_bad++; $display("FAIL chg_regrant: rom_cs=%b addr=%h expected 1/41", rom_cs, rom_addr);
    end
    tick(); tick();
    n_cmp++; if (ok[1] !== 1'b1 || dt[1] !== romfn(20'h41)) begin
      n_bad++; $display("FAIL chg_served41: ok=%b data=%h expected 1/%h", ok[1], dt[1], romfn(20'h41));
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    do_reset();
    rom_ok = 1;
    cs[0] = 1; ad[0] = 20'h5;
    tick(); tick(); tick();
    n_cmp++; if (ok[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: ok0=%b expected 1", ok[0]); end
    rom_ok = 0;
    cs[2] = 1; ad[2] = 20'h99;
    tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 20'h99) begin
      n_bad++; $display("FAIL rmid_grant: rom_cs=%b addr=%h expected 1/99", rom_cs, rom_addr);
    end
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rom_cs !== 1'b0 || ok[0] !== 1'b0 || ok[2] !== 1'b0) begin
      n_bad++; $display("FAIL rmid_abort: rom_cs=%b ok0=%b ok2=%b expected 0/0/0", rom_cs, ok[0], ok[2]);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (rom_cs !== 1'b1 || rom_addr !== 20'h5) begin
      n_bad++; $display("FAIL rmid_first: rom_cs=%b addr=%h expected 1/00005", rom_cs, rom_addr);
    end
    rom_ok = 1;
    found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      tick();
      if (rom_cs && rom_addr == 20'h99) found = 1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rmid_reissue: got no grant expected addr 99 within 12 cycles"); end
    tick(); tick();
    n_cmp++; if (ok[0] !== 1'b1 || ok[2] !== 1'b1 || dt[2] !== romfn(20'h99)) begin
      n_bad++; $display("FAIL rmid_final: ok0=%b ok2=%b data2=%h expected 1/1/%h", ok[0], ok[2], dt[2], romfn(20'h99));
    end
  endtask

  task automatic test_hold();
    do_reset();
    rom_ok = 1;
    cs[2] = 1; ad[2] = 20'h55;
    tick(); tick(); tick();
    rom_ok = 0;
    cs[0] = 1; ad[0] = 20'h66;
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if (ok[2] !== 1'b1 || dt[2] !== romfn(20'h55)) begin
        n_bad++; $display("FAIL hold_c%0d: ok2=%b data2=%h expected 1/%h", c, ok[2], dt[2], romfn(20'h55));
      end
      if (c == 7) rom_ok = 1;
      tick();
    end
    n_cmp++; if (ok[0] !== 1'b1 || dt[0] !== romfn(20'h66)) begin
      n_bad++; $display("FAIL hold_req0: ok0=%b data0=%h expected 1/%h", ok[0], dt[0], romfn(20'h66));
    end
  endtask

  task automatic test_identical();
    int   grants;
    logic prev;
    do_reset();
    rom_ok = 1;
    for (int i = 0; i < 3; i++) begin cs[i] = 1; ad[i] = 20'h123; end
    grants = 0; prev = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (rom_cs && !prev) grants++;
      prev = rom_cs;
    end
    n_cmp++; if (grants != 3) begin n_bad++; $display("FAIL ident_grants: got %0d expected 3", grants); end
    n_cmp++; if (ok[0] !== 1'b1 || ok[1] !== 1'b1 || ok[2] !== 1'b1) begin
      n_bad++; $display("FAIL ident_ok: ok=%b%b%b expected 1,1,1", ok[0], ok[1], ok[2]);
    end
  endtask

  task automatic test_random();
    int   shown;
    logic eok;
    logic good;
    do_reset();
    use_manual = 1;
    shown = 0;
    for (int c = 0; c < 800; c++) begin
      good = (rom_cs === m_busy) && (rom_addr === m_addr);
      for (int i = 0; i < 3; i++) begin
        eok = cs[i] && m_valid[i] && (ad[i] == m_served[i]);
        if (ok[i] !== eok || dt[i] !== m_data[i]) good = 0;
      end
      n_cmp++;
      if (!good) begin
        n_bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_c%0d: rom_cs=%b addr=%h ok=%b%b%b expected rom_cs=%b addr=%h",
                   c, rom_cs, rom_addr, ok[0], ok[1], ok[2], m_busy, m_addr);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) cs[i] = ~cs[i];
        if ($urandom_range(0, 3) == 0) ad[i] = 20'($urandom_range(0, 3));
      end
      rom_ok = 1'($urandom_range(0, 1));
      manual = $urandom;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin cs[i] = 0; ad[i] = '0; end
    rom_ok = 0; use_manual = 0; manual = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stale_ok();
    test_addr_change();
    test_reset_mid();
    test_hold();
    test_identical();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtframe_tilerom_arb.md
JTFRAME_TILEROM_ARB -- requirements
Module: jtframe_tilerom_arb

Interface
REQ-001 Parameter AW, default 20: ROM address width for all requesters and the ROM port.
REQ-002 Parameter DW, default 32: ROM data width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_cs, req1_cs, req2_cs  input  1 each  requester n wants data for reqn_addr.
REQ-006 req0_addr, req1_addr, req2_addr  input  AW each  requester n address.
REQ-007 req0_ok, req1_ok, req2_ok  output  1 each  reqn_data is valid for the current reqn_addr.
REQ-008 req0_data, req1_data, req2_data  output  DW each  latched ROM data per requester.
REQ-009 rom_cs  output  1  request to the shared ROM/SDRAM port.
REQ-010 rom_addr  output  AW  address presented to the ROM port.
REQ-011 rom_ok  input  1  ROM port data-valid strobe.
REQ-012 rom_data  input  DW  ROM port data.

Function
REQ-013 Per requester n, the block SHALL hold served_addr_n (AW), valid_n (1) and data_n (DW), with reqn_data = data_n.
REQ-014 reqn_ok SHALL be combinational: reqn_cs & valid_n & (reqn_addr == served_addr_n).
REQ-015 Requester n SHALL be pending when reqn_cs=1 and (valid_n=0 or reqn_addr != served_addr_n).
REQ-016 The FSM SHALL have states IDLE, SETTLE, WAIT.
REQ-017 In IDLE with >=1 pending requester, the block SHALL grant one round-robin, starting at (last+1) mod 3, where last is the previously completed grant, and SHALL register rom_addr=reqn_addr, rom_cs=1, gnt=n, then enter SETTLE.
REQ-018 In IDLE with no pending requester, rom_cs SHALL stay 0 and rom_addr SHALL hold its value.
REQ-019 SETTLE SHALL last exactly one cycle; rom_ok is ignored there (stale-ok protection), then WAIT.
REQ-020 In WAIT, on rom_ok=1 the block SHALL latch data_gnt=rom_data, served_addr_gnt=rom_addr, valid_gnt=1, set last=gnt, rom_cs=0, and return to IDLE.
REQ-021 In WAIT with rom_ok=0, all outputs SHALL hold; no timeout exists.
REQ-022 Minimum latency: pending detected at edge k -> reqn_ok high after edge k+2 (rom_ok high throughout).
REQ-023 A requester whose address changes or whose cs drops while granted SHALL NOT abort the transfer; the transfer completes for the registered rom_addr and the requester becomes pending again if its address differs.
REQ-024 rom_addr SHALL NOT change while rom_cs=1.
REQ-025 Back-to-back: returning to IDLE and granting the next pending requester SHALL take one cycle, so rom_cs drops low for at least one cycle between grants.
REQ-026 Requesters not granted SHALL keep their data_n, served_addr_n and reqn_ok unchanged during another requester's transfer.
REQ-027 Identical addresses on multiple requesters SHALL still be served as separate transfers; there is no sharing of data between requesters.

Reset
REQ-028 While rst=1, state=IDLE, rom_cs=0, rom_addr=0, gnt=0, last=2 (so requester 0 has first priority), all valid_n=0, served_addr_n=0, data_n=0, therefore all reqn_ok=0.
REQ-029 rst asserted mid-transfer SHALL abort immediately; after release any requester still asserting cs is pending and re-requested.

Verification
REQ-030 Single request: req0_cs=1, req0_addr=0x00123, rom_ok tied 1, rom_data=0xDEADBEEF -> rom_cs high one edge after pending, req0_ok=1 and req0_data=0xDEADBEEF two edges after grant.
REQ-031 Round-robin: all three cs=1 from reset with distinct addresses 0x10, 0x20, 0x30 -> grant order 0,1,2; then req0_addr->0x11 and req2_addr->0x31 together -> order 0,2.
REQ-032 Stale ok: rom_ok=1 during SETTLE and 0 afterwards for 5 cycles, then 1 -> data latched only on the later rom_ok, never in SETTLE.
REQ-033 Address change mid-transfer: req1_addr 0x40->0x41 during WAIT -> transfer completes with served_addr_1=0x40, req1_ok stays 0, new request for 0x41 issued.
REQ-034 Reset mid-WAIT: assert rst while rom_cs=1 -> rom_cs=0 and all reqn_ok=0 immediately; after release, the same request is reissued.
REQ-035 Hold check: req2 served at 0x55; req0 transfer in progress -> req2_ok stays 1 and req2_data stays unchanged throughout.
